// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data memory: load/store op codes, FSM states
// and the latched request record.
package data_mem_ctrl_pkg;

  localparam logic [2:0] RD_NONE = 3'd0;
  localparam logic [2:0] RD_LB   = 3'd1;
  localparam logic [2:0] RD_LH   = 3'd2;
  localparam logic [2:0] RD_LW   = 3'd3;
  localparam logic [2:0] RD_LBU  = 3'd4;
  localparam logic [2:0] RD_LHU  = 3'd5;

  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_SB   = 2'd1;
  localparam logic [1:0] WR_SH   = 2'd2;
  localparam logic [1:0] WR_SW   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Codes 6 and 7 are reserved and behave as "no load".
  function automatic logic is_load(input logic [2:0] rd);
    return (rd >= RD_LB) && (rd <= RD_LHU);
  endfunction

  function automatic logic is_req(input logic [2:0] rd, input logic [1:0] wr);
    return is_load(rd) || (wr != WR_NONE);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_store_align.sv
// Byte/halfword lane selection, load extension and store merge (purely combinational).
module load_store_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  rd_op,
  input  logic [1:0]  wr_op,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];

    load_val = '0;
    case (rd_op)
      RD_LB:   load_val = {{24{b[7]}}, b};
      RD_LH:   load_val = {{16{h[15]}}, h};
      RD_LW:   load_val = word;
      RD_LBU:  load_val = {24'd0, b};
      RD_LHU:  load_val = {16'd0, h};
      default: load_val = '0;
    endcase

    // Read-modify-write: untouched lanes keep the current word contents.
    store_word = word;
    case (wr_op)
      WR_SB: store_word[8*lane +: 8] = wdata[7:0];
      WR_SH: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      WR_SW:   store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory for the MEM stage: stalls the pipeline for LATENCY cycles
// per access, then releases it for one DONE cycle.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  MEM_READ,
  input  logic [1:0]  MEM_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY_WAIT
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state;
  logic [3:0]  cnt;
  mem_req_t    req_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] word, load_val, store_word;
  logic        req, fire;
  logic [AW-1:0] widx;

  assign req  = is_req(MEM_READ, MEM_WRITE);
  assign widx = req_q.addr[AW+1:2];
  assign word = mem[widx];
  assign fire = (state == ST_ACCESS) && (cnt == 4'd0);

  // The IDLE cycle that sees the request already counts as the first stall cycle.
  assign BUSY_WAIT = RESET && (((state == ST_IDLE) && req) || (state == ST_ACCESS));

  load_store_align u_align (
    .word       (word),
    .lane       (req_q.addr[1:0]),
    .rd_op      (req_q.rd),
    .wr_op      (req_q.wr),
    .wdata      (req_q.wdata),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      READ_DATA <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            req_q <= '{rd: MEM_READ, wr: MEM_WRITE, addr: ADDRESS, wdata: WRITE_DATA};
            cnt   <= 4'(LATENCY - 2);
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            state <= ST_DONE;
            // A store wins over a simultaneous load; READ_DATA then holds.
            if (req_q.wr == WR_NONE && is_load(req_q.rd)) READ_DATA <= load_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array is never reset; reset forces IDLE so an aborted access cannot fire.
  always_ff @(posedge CLK) begin
    if (fire && req_q.wr != WR_NONE) mem[widx] <= store_word;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed + randomized bench for data_mem_ctrl against a byte-addressed reference model.
module tb_data_mem_ctrl;

  localparam int LAT   = 4;
  localparam int DEPTH = 256;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [2:0]  MEM_READ;
  logic [1:0]  MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rm [DEPTH*4];
  logic [31:0] rd_exp;

  data_mem_ctrl #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MEM_READ   (MEM_READ),
    .MEM_WRITE  (MEM_WRITE),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSY_WAIT  (BUSY_WAIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: little-endian byte array, address wraps at DEPTH*4 bytes.
  function automatic logic [31:0] model_load(input logic [2:0] rd, input logic [31:0] a);
    int ab = int'(a) & (DEPTH*4 - 1);
    int hb = ab & ~1;
    int wb = ab & ~3;
    logic [15:0] h = {rm[hb+1], rm[hb]};
    case (rd)
      3'd1: return {{24{rm[ab][7]}}, rm[ab]};
      3'd2: return {{16{h[15]}}, h};
      3'd3: return {rm[wb+3], rm[wb+2], rm[wb+1], rm[wb]};
      3'd4: return {24'd0, rm[ab]};
      3'd5: return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d);
    int ab = int'(a) & (DEPTH*4 - 1);
    int hb = ab & ~1;
    int wb = ab & ~3;
    case (wr)
      2'd1: rm[ab] = d[7:0];
      2'd2: begin rm[hb] = d[7:0]; rm[hb+1] = d[15:8]; end
      2'd3: begin
        rm[wb] = d[7:0]; rm[wb+1] = d[15:8]; rm[wb+2] = d[23:16]; rm[wb+3] = d[31:24];
      end
      default: ;
    endcase
  endtask

  // One full access starting in IDLE. Inputs are scrambled during ACCESS and DONE
  // to show they are ignored there.
  task automatic access(input logic [2:0] rd, input logic [1:0] wr,
                        input logic [31:0] a, input logic [31:0] d);
    logic is_rq;
    is_rq = (rd >= 3'd1 && rd <= 3'd5) || (wr != 2'd0);
    @(negedge CLK);
    MEM_READ = rd; MEM_WRITE = wr; ADDRESS = a; WRITE_DATA = d;
    #1;
    chk("busy_idle", {31'd0, BUSY_WAIT}, {31'd0, is_rq});
    if (!is_rq) return;
    for (int i = 1; i < LAT; i++) begin
      @(negedge CLK);
      chk("busy_access", {31'd0, BUSY_WAIT}, 32'd1);
      MEM_READ = 3'($urandom); MEM_WRITE = 2'($urandom);
      ADDRESS = $urandom; WRITE_DATA = $urandom;
    end
    if (wr != 2'd0) model_store(wr, a, d);
    else rd_exp = model_load(rd, a);
    @(negedge CLK);
    chk("busy_done", {31'd0, BUSY_WAIT}, 32'd0);
    chk("read_data", READ_DATA, rd_exp);
    MEM_READ = 3'd0; MEM_WRITE = 2'd3; ADDRESS = $urandom; WRITE_DATA = $urandom;
  endtask

  initial begin
    RESET = 1'b0; MEM_READ = 3'd3; MEM_WRITE = 2'd0; ADDRESS = 32'h10; WRITE_DATA = 32'h0;
    rd_exp = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("reset_read_data", READ_DATA, 32'd0);
      chk("reset_busy", {31'd0, BUSY_WAIT}, 32'd0);
    end
    MEM_READ = 3'd0;
    RESET = 1'b1;

    // Fill the array so every model byte is defined.
    for (int i = 0; i < DEPTH; i++) access(3'd0, 2'd3, 32'(i*4), $urandom);

    // Store then load
    access(3'd0, 2'd3, 32'h10, 32'hDEADBEEF);
    access(3'd3, 2'd0, 32'h10, 32'h0);
    chk("lw_deadbeef", READ_DATA, 32'hDEADBEEF);

    // Byte lanes and extension
    access(3'd0, 2'd1, 32'h13, 32'h12345680);
    access(3'd1, 2'd0, 32'h13, 32'h0);
    chk("lb_sext", READ_DATA, 32'hFFFFFF80);
    access(3'd4, 2'd0, 32'h13, 32'h0);
    chk("lbu_zext", READ_DATA, 32'h00000080);
    access(3'd3, 2'd0, 32'h10, 32'h0);
    chk("lw_after_sb", READ_DATA, 32'h80ADBEEF);

    // Halfword, ADDRESS[0] ignored
    access(3'd0, 2'd2, 32'h22, 32'hABCD1234);
    access(3'd2, 2'd0, 32'h23, 32'h0);
    chk("lh_upper", READ_DATA, 32'h00001234);
    access(3'd3, 2'd0, 32'h20, 32'h0);
    chk("lw_after_sh_hi", {16'd0, READ_DATA[31:16]}, 32'h00001234);

    // Simultaneous read+write: store happens, READ_DATA holds
    access(3'd3, 2'd3, 32'h60, 32'hCAFEF00D);
    chk("simul_hold", READ_DATA, 32'h1234_0000 | {16'd0, rm[8'h21], rm[8'h20]});
    access(3'd3, 2'd0, 32'h60, 32'h0);
    chk("simul_written", READ_DATA, 32'hCAFEF00D);

    // Reset mid-ACCESS with ADDRESS changed: no write anywhere
    @(negedge CLK);
    MEM_READ = 3'd0; MEM_WRITE = 2'd3; ADDRESS = 32'h30; WRITE_DATA = 32'h11111111;
    @(negedge CLK);
    ADDRESS = 32'h40;
    #1 RESET = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, BUSY_WAIT}, 32'd0);
    chk("midreset_read_data", READ_DATA, 32'd0);
    MEM_WRITE = 2'd0;
    #1 RESET = 1'b1;
    rd_exp = 32'd0;
    access(3'd3, 2'd0, 32'h30, 32'h0);
    access(3'd3, 2'd0, 32'h40, 32'h0);

    // Store with ADDRESS changed mid-ACCESS hits the latched address only
    access(3'd0, 2'd3, 32'h50, 32'h5A5A5A5A);
    access(3'd3, 2'd0, 32'h50, 32'h0);
    chk("latched_addr", READ_DATA, 32'h5A5A5A5A);

    // Randomized ops incl. reserved codes, idle cycles and high address bits
    for (int i = 0; i < 300; i++)
      access(3'($urandom), 2'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom, $urandom);

    // Readback of the whole array catches stray writes
    for (int i = 0; i < DEPTH; i++) access(3'd3, 2'd0, 32'(i*4), 32'h0);

    @(negedge CLK);
    MEM_WRITE = 2'd0; MEM_READ = 3'd0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
